branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning table index width (2^IDX_W two-bit counters, index = PC[IDX_W+1:2]).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports ID_IsBranch_i, ID_PC_i, ID_BrTarget_i: input, 1/32/32, conditional branch decoded in ID, its PC and computed target.
REQ-005 SHALL have port ID_PredTaken_o, output, 1, predict-taken for the ID branch; drives PC-select to ID_BrTarget_i and an IF flush.
REQ-006 SHALL have ports WriteEX_i, FlushEX_i, WriteMEM_i: input, 1 each, ID/EX and EX/MEM enables and ID/EX flush from stall control.
REQ-007 SHALL have ports EX_IsBranch_i, EX_BranchTaken_i: input, 1 each, resolved branch outcome in EX.
REQ-008 SHALL have port EX_WrongPredict_o, output, 1, misprediction in EX; feeds stall control.
REQ-009 SHALL have port EX_RecoverPC_o, output, 32, correct next PC on misprediction.
REQ-010 SHALL have ports BrCount_o, MissCount_o: output, 32 each, resolved-branch and misprediction counters.

Function
REQ-011 SHALL hold 2^IDX_W two-bit saturating counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-012 SHALL drive ID_PredTaken_o = ID_IsBranch_i & counter[idx(ID_PC_i)][1], combinationally, zero-cycle latency.
REQ-013 SHALL hold an ID/EX record {valid, pred, idx, PC+4, target}, loaded from ID when WriteEX_i=1; valid = ID_IsBranch_i.
REQ-014 SHALL clear record valid when FlushEX_i=1, overriding WriteEX_i.
REQ-015 SHALL hold the record unchanged when WriteEX_i=0 and FlushEX_i=0.
REQ-016 SHALL drive EX_WrongPredict_o = valid & EX_IsBranch_i & (pred != EX_BranchTaken_i), combinationally.
REQ-017 SHALL drive EX_RecoverPC_o = target when EX_BranchTaken_i=1, else PC+4.
REQ-018 SHALL update counter[idx] once per resolved branch, only when valid & EX_IsBranch_i & WriteMEM_i: increment on taken, decrement on not-taken.
REQ-019 SHALL saturate counters: no increment above 11, no decrement below 00.
REQ-020 SHALL give a same-cycle ID lookup of an index being updated the pre-update value (no bypass).
REQ-021 SHALL increment BrCount_o under the REQ-018 condition, and MissCount_o when that condition and EX_WrongPredict_o hold; both saturate at 0xFFFFFFFF.
REQ-022 SHALL not update any counter while WriteMEM_i=0 (memory stall), so a stalled branch counts exactly once.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set all table entries to 01 (WNT), record valid to 0, and BrCount_o and MissCount_o to 0.
REQ-024 SHALL, after reset, drive ID_PredTaken_o=0 and EX_WrongPredict_o=0 until a branch is presented.
REQ-025 SHALL let rst=1 mid-stall discard any in-flight record and suppress its table update.

Structure
REQ-026 SHALL place the counter-state encodings (SNT/WNT/WT/ST) and the IDX_W default in a shared package used by the bench.
REQ-027 SHALL isolate the table in one sub-module, bht_2bit (read port, update port with taken flag).

Verification
REQ-028 SHALL cover: reset, then a branch at PC 0x40 target 0x80, actual taken -> ID_PredTaken_o=0, EX_WrongPredict_o=1, EX_RecoverPC_o=0x80, entry 0 becomes 10, counts 1/1.
REQ-029 SHALL cover: the same branch presented again and taken -> ID_PredTaken_o=1, no mispredict, entry 0 becomes 11, counts 2/1.
REQ-030 SHALL cover: five more taken branches at the same index -> entry stays 11; then one not-taken -> entry 10, EX_RecoverPC_o=0x44.
REQ-031 SHALL cover: a branch held in EX with WriteMEM_i=0 for 3 cycles -> BrCount_o increments exactly once, after release.
REQ-032 SHALL cover: FlushEX_i=1 together with WriteEX_i=1 on a branch -> record invalid, EX_WrongPredict_o=0, no table change.
REQ-033 SHALL cover: rst=1 while a mispredicting branch is in EX -> next cycle all entries 01, counts 0, EX_WrongPredict_o=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the 2-bit branch predictor.
//   bht_state_e   : two-bit saturating counter encodings (SNT/WNT/WT/ST)
//   IDX_W_DEFAULT : default table index width
//   bht_next()    : saturating counter step for a resolved branch
package branch_predictor_pkg;

    localparam int IDX_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Move one step toward the resolved direction, sticking at either end.
    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = bht_state_e'(cur + 2'd1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = bht_state_e'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2^IDX_W two-bit saturating counters.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_state  : combinational read port (zero-latency lookup)
//   upd_en, upd_idx,
//   upd_taken          : update port; one saturating step per asserted cycle
// A read of the entry being updated in the same cycle returns the old value;
// the new value becomes visible after the clock edge.
module bht_2bit
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_e       rd_state,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_state_e table_reg [ENTRIES];

    assign rd_state = table_reg[rd_idx];

    // Reset has priority, so an update presented in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_reg[i] <= WNT;
            end
        end else if (upd_en) begin
            table_reg[upd_idx] <= bht_next(table_reg[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor for a 5-stage pipeline.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   ID_IsBranch_i/PC_i/BrTarget_i   : conditional branch decoded in ID
//   ID_PredTaken_o                  : combinational predict-taken for the ID branch
//   WriteEX_i, FlushEX_i, WriteMEM_i: pipeline register enables / ID-EX flush
//   EX_IsBranch_i, EX_BranchTaken_i : resolved outcome in EX
//   EX_WrongPredict_o               : misprediction detected in EX
//   EX_RecoverPC_o                  : correct next PC for the EX branch
//   BrCount_o, MissCount_o          : saturating resolved / mispredicted counts
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_IsBranch_i,
    input  logic [31:0] ID_PC_i,
    input  logic [31:0] ID_BrTarget_i,
    output logic        ID_PredTaken_o,
    input  logic        WriteEX_i,
    input  logic        FlushEX_i,
    input  logic        WriteMEM_i,
    input  logic        EX_IsBranch_i,
    input  logic        EX_BranchTaken_i,
    output logic        EX_WrongPredict_o,
    output logic [31:0] EX_RecoverPC_o,
    output logic [31:0] BrCount_o,
    output logic [31:0] MissCount_o
);

    logic [IDX_W-1:0] id_idx;
    bht_state_e       id_state;

    // ID/EX record of the prediction made for the branch now in EX
    logic             ex_valid_reg;
    logic             ex_pred_reg;
    logic [IDX_W-1:0] ex_idx_reg;
    logic [31:0]      ex_pc4_reg;
    logic [31:0]      ex_target_reg;

    logic [31:0]      br_count_reg;
    logic [31:0]      miss_count_reg;

    logic             resolve;

    // Word-aligned PCs: bits [1:0] carry no information.
    assign id_idx = ID_PC_i[IDX_W+1:2];

    bht_2bit #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (id_idx),
        .rd_state  (id_state),
        .upd_en    (resolve),
        .upd_idx   (ex_idx_reg),
        .upd_taken (EX_BranchTaken_i)
    );

    assign ID_PredTaken_o = ID_IsBranch_i & id_state[1];

    // Counting only when EX/MEM advances makes a stalled branch count once.
    assign resolve = ex_valid_reg & EX_IsBranch_i & WriteMEM_i;

    assign EX_WrongPredict_o = ex_valid_reg & EX_IsBranch_i & (ex_pred_reg != EX_BranchTaken_i);
    assign EX_RecoverPC_o    = EX_BranchTaken_i ? ex_target_reg : ex_pc4_reg;

    assign BrCount_o   = br_count_reg;
    assign MissCount_o = miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_pred_reg   <= 1'b0;
            ex_idx_reg    <= '0;
            ex_pc4_reg    <= '0;
            ex_target_reg <= '0;
        end else if (FlushEX_i) begin
            // Flush wins over a simultaneous load; payload is don't-care.
            ex_valid_reg <= 1'b0;
        end else if (WriteEX_i) begin
            ex_valid_reg  <= ID_IsBranch_i;
            ex_pred_reg   <= ID_PredTaken_o;
            ex_idx_reg    <= id_idx;
            ex_pc4_reg    <= ID_PC_i + 32'd4;
            ex_target_reg <= ID_BrTarget_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_reg   <= '0;
            miss_count_reg <= '0;
        end else if (resolve) begin
            if (br_count_reg != '1) begin
                br_count_reg <= br_count_reg + 32'd1;
            end
            if (EX_WrongPredict_o && (miss_count_reg != '1)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IW = IDX_W_DEFAULT;
    localparam int NE = 1 << IW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ID_IsBranch = 1'b0;
    logic [31:0] ID_PC = '0;
    logic [31:0] ID_BrTarget = '0;
    logic        ID_PredTaken;
    logic        WriteEX = 1'b0;
    logic        FlushEX = 1'b0;
    logic        WriteMEM = 1'b0;
    logic        EX_IsBranch = 1'b0;
    logic        EX_BranchTaken = 1'b0;
    logic        EX_WrongPredict;
    logic [31:0] EX_RecoverPC;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IW)) dut (
        .clk               (clk),
        .rst               (rst),
        .ID_IsBranch_i     (ID_IsBranch),
        .ID_PC_i           (ID_PC),
        .ID_BrTarget_i     (ID_BrTarget),
        .ID_PredTaken_o    (ID_PredTaken),
        .WriteEX_i         (WriteEX),
        .FlushEX_i         (FlushEX),
        .WriteMEM_i        (WriteMEM),
        .EX_IsBranch_i     (EX_IsBranch),
        .EX_BranchTaken_i  (EX_BranchTaken),
        .EX_WrongPredict_o (EX_WrongPredict),
        .EX_RecoverPC_o    (EX_RecoverPC),
        .BrCount_o         (BrCount),
        .MissCount_o       (MissCount)
    );

    // Reference model: counters as integers 0..3, pipeline record as plain fields.
    int          m_tbl [NE];
    bit          m_v;
    bit          m_pred;
    int          m_idx;
    logic [31:0] m_pc4;
    logic [31:0] m_tgt;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function bit exp_pred();
        return ID_IsBranch && (m_tbl[idx_of(ID_PC)] >= 2);
    endfunction

    function bit exp_wrong();
        return m_v && EX_IsBranch && (m_pred != EX_BranchTaken);
    endfunction

    task automatic model_step();
        bit res;
        bit wrong;
        bit p;
        int ri;
        if (rst) begin
            for (int i = 0; i < NE; i++) m_tbl[i] = 1;
            m_v = 0;
            m_br = 0;
            m_miss = 0;
        end else begin
            res   = m_v && EX_IsBranch && WriteMEM;
            wrong = exp_wrong();
            p     = exp_pred();
            ri    = m_idx;
            if (FlushEX) begin
                m_v = 0;
            end else if (WriteEX) begin
                m_v    = ID_IsBranch;
                m_pred = p;
                m_idx  = idx_of(ID_PC);
                m_pc4  = ID_PC + 32'd4;
                m_tgt  = ID_BrTarget;
            end
            if (res) begin
                if (EX_BranchTaken) m_tbl[ri] = (m_tbl[ri] == 3) ? 3 : m_tbl[ri] + 1;
                else                m_tbl[ri] = (m_tbl[ri] == 0) ? 0 : m_tbl[ri] - 1;
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (wrong && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            end
        end
    endtask

    // Advance one clock: model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit r, input bit ib, input logic [31:0] pc, input logic [31:0] tgt,
                          input bit wex, input bit fex, input bit wmem, input bit exb, input bit ext);
        rst = r; ID_IsBranch = ib; ID_PC = pc; ID_BrTarget = tgt;
        WriteEX = wex; FlushEX = fex; WriteMEM = wmem;
        EX_IsBranch = exb; EX_BranchTaken = ext;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 1, 0, 1, 0, 0);
        tick();
        tick();
        set_in(0, 0, 0, 0, 1, 0, 1, 1, 1);
        #1;
        n_cmp++;
        if (ID_PredTaken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%0b exp=0", ID_PredTaken); end
        n_cmp++;
        if (EX_WrongPredict !== 1'b0) begin n_fail++; $display("FAIL reset_wrong got=%0b exp=0", EX_WrongPredict); end
        n_cmp++;
        if (BrCount !== 32'd0 || MissCount !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", BrCount, MissCount);
        end
        for (int i = 0; i < NE; i++) begin
            n_cmp++;
            if (dut.u_bht.table_reg[i] !== WNT) begin
                n_fail++; $display("FAIL reset_entry[%0d] got=%0d exp=1", i, dut.u_bht.table_reg[i]);
            end
        end
        tick();
        $display("reset: checked prediction, mispredict, counts and %0d entries", NE);
    endtask

    // One branch: present in ID, then resolve in EX. Checks use spec constants.
    task automatic run_branch(input string name, input logic [31:0] pc, input logic [31:0] tgt, input bit taken,
                              input bit exp_p, input bit exp_w, input logic [31:0] exp_rec,
                              input int exp_entry, input int exp_br, input int exp_miss);
        set_in(0, 1, pc, tgt, 1, 0, 1, 0, 0);
        #1;
        n_cmp++;
        if (ID_PredTaken !== exp_p) begin n_fail++; $display("FAIL %s_pred got=%0b exp=%0b", name, ID_PredTaken, exp_p); end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 1, 1, taken);
        #1;
        n_cmp++;
        if (EX_WrongPredict !== exp_w) begin n_fail++; $display("FAIL %s_wrong got=%0b exp=%0b", name, EX_WrongPredict, exp_w); end
        n_cmp++;
        if (EX_RecoverPC !== exp_rec) begin n_fail++; $display("FAIL %s_recover got=%h exp=%h", name, EX_RecoverPC, exp_rec); end
        tick();
        n_cmp++;
        if (int'(dut.u_bht.table_reg[idx_of(pc)]) != exp_entry) begin
            n_fail++; $display("FAIL %s_entry got=%0d exp=%0d", name, dut.u_bht.table_reg[idx_of(pc)], exp_entry);
        end
        n_cmp++;
        if (BrCount !== 32'(exp_br) || MissCount !== 32'(exp_miss)) begin
            n_fail++; $display("FAIL %s_counts got=%0d/%0d exp=%0d/%0d", name, BrCount, MissCount, exp_br, exp_miss);
        end
        $display("%s: pc=%h taken=%0b pred=%0b wrong=%0b entry=%0d counts=%0d/%0d",
                 name, pc, taken, exp_p, exp_w, exp_entry, BrCount, MissCount);
    endtask

    task automatic test_first_branch();
        run_branch("first", 32'h40, 32'h80, 1, 0, 1, 32'h80, 2, 1, 1);
    endtask

    task automatic test_repeat_taken();
        run_branch("repeat", 32'h40, 32'h80, 1, 1, 0, 32'h80, 3, 2, 1);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            run_branch("sat", 32'h40, 32'h80, 1, 1, 0, 32'h80, 3, 3 + k, 1);
        end
        run_branch("not_taken", 32'h40, 32'h80, 0, 1, 1, 32'h44, 2, 8, 2);
    endtask

    task automatic test_mem_stall();
        logic [31:0] base;
        base = BrCount;
        set_in(0, 1, 32'h104, 32'h200, 1, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (BrCount !== base) begin n_fail++; $display("FAIL stall_hold[%0d] got=%0d exp=%0d", c, BrCount, base); end
        end
        set_in(0, 0, 0, 0, 1, 0, 1, 1, 1);
        tick();
        n_cmp++;
        if (BrCount !== base + 32'd1) begin n_fail++; $display("FAIL stall_release got=%0d exp=%0d", BrCount, base + 1); end
        tick();
        n_cmp++;
        if (BrCount !== base + 32'd1) begin n_fail++; $display("FAIL stall_once got=%0d exp=%0d", BrCount, base + 1); end
        n_cmp++;
        if (dut.u_bht.table_reg[1] !== WT) begin n_fail++; $display("FAIL stall_entry got=%0d exp=2", dut.u_bht.table_reg[1]); end
        $display("mem_stall: held 3 cycles, BrCount %0d -> %0d", base, BrCount);
    endtask

    task automatic test_flush();
        logic [31:0] b0, m0;
        b0 = BrCount; m0 = MissCount;
        set_in(0, 1, 32'h48, 32'h90, 1, 1, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 1, 1, 1);
        #1;
        n_cmp++;
        if (EX_WrongPredict !== 1'b0) begin n_fail++; $display("FAIL flush_wrong got=%0b exp=0", EX_WrongPredict); end
        tick();
        n_cmp++;
        if (dut.u_bht.table_reg[2] !== WNT) begin n_fail++; $display("FAIL flush_entry got=%0d exp=1", dut.u_bht.table_reg[2]); end
        n_cmp++;
        if (BrCount !== b0 || MissCount !== m0) begin
            n_fail++; $display("FAIL flush_counts got=%0d/%0d exp=%0d/%0d", BrCount, MissCount, b0, m0);
        end
        $display("flush: record dropped, counts %0d/%0d", BrCount, MissCount);
    endtask

    task automatic test_reset_mid();
        set_in(0, 1, 32'h54, 32'hA0, 1, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        n_cmp++;
        if (EX_WrongPredict !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_wrong got=%0b exp=1", EX_WrongPredict); end
        rst = 1'b1;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
        #1;
        n_cmp++;
        if (EX_WrongPredict !== 1'b0) begin n_fail++; $display("FAIL rstmid_wrong got=%0b exp=0", EX_WrongPredict); end
        n_cmp++;
        if (BrCount !== 32'd0 || MissCount !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", BrCount, MissCount);
        end
        for (int i = 0; i < NE; i++) begin
            n_cmp++;
            if (dut.u_bht.table_reg[i] !== WNT) begin
                n_fail++; $display("FAIL rstmid_entry[%0d] got=%0d exp=1", i, dut.u_bht.table_reg[i]);
            end
        end
        tick();
        n_cmp++;
        if (BrCount !== 32'd0) begin n_fail++; $display("FAIL rstmid_suppress got=%0d exp=0", BrCount); end
        $display("reset_mid: in-flight branch discarded, counts %0d/%0d", BrCount, MissCount);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 49) == 0),
                   $urandom_range(0, 1) == 1,
                   {20'h0, 4'($urandom_range(0, 3)), 6'($urandom), 2'b00},
                   {16'h0, 14'($urandom), 2'b00},
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1);
            #1;
            n_cmp++;
            if (ID_PredTaken !== exp_pred()) begin
                n_fail++; $display("FAIL rnd_pred cyc=%0d got=%0b exp=%0b", c, ID_PredTaken, exp_pred());
            end
            n_cmp++;
            if (EX_WrongPredict !== exp_wrong()) begin
                n_fail++; $display("FAIL rnd_wrong cyc=%0d got=%0b exp=%0b", c, EX_WrongPredict, exp_wrong());
            end
            if (m_v) begin
                n_cmp++;
                if (EX_RecoverPC !== (EX_BranchTaken ? m_tgt : m_pc4)) begin
                    n_fail++; $display("FAIL rnd_recover cyc=%0d got=%h exp=%h", c, EX_RecoverPC,
                                       EX_BranchTaken ? m_tgt : m_pc4);
                end
            end
            n_cmp++;
            if (BrCount !== m_br || MissCount !== m_miss) begin
                n_fail++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", c, BrCount, MissCount, m_br, m_miss);
            end
            tick();
        end
        for (int i = 0; i < NE; i++) begin
            n_cmp++;
            if (int'(dut.u_bht.table_reg[i]) != m_tbl[i]) begin
                n_fail++; $display("FAIL rnd_entry[%0d] got=%0d exp=%0d", i, dut.u_bht.table_reg[i], m_tbl[i]);
            end
        end
        $display("random: 400 cycles, counts %0d/%0d, new errors %0d", BrCount, MissCount, n_fail - errs_before);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) m_tbl[i] = 1;
        m_v = 0; m_pred = 0; m_idx = 0; m_pc4 = 0; m_tgt = 0; m_br = 0; m_miss = 0;
        test_reset();
        test_first_branch();
        test_repeat_taken();
        test_saturate();
        test_mem_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
